// File: rtl/polynomial_tile_scheduler.sv
// Producer-side sequencer for the tiled polynomial multiplier: captures A and B
// on start and issues every (A tile, B tile) pair, A inner / B outer, over valid/ack.
module polynomial_tile_scheduler #(
  parameter int DATA_WIDTH        = 16,
  parameter int POLY_A_WIDTH      = 27,
  parameter int POLY_B_WIDTH      = 27,
  parameter int POLY_A_TILE_WIDTH = 3,
  parameter int POLY_B_TILE_WIDTH = 9,
  localparam int NA  = POLY_A_WIDTH / POLY_A_TILE_WIDTH,
  localparam int NB  = POLY_B_WIDTH / POLY_B_TILE_WIDTH,
  localparam int OW  = $clog2(POLY_A_WIDTH + POLY_B_WIDTH - 1),
  localparam int AIW = (NA > 1) ? $clog2(NA) : 1,
  localparam int BIW = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic [POLY_A_WIDTH-1:0][DATA_WIDTH-1:0]        poly_a,
  input  logic [POLY_B_WIDTH-1:0][DATA_WIDTH-1:0]        poly_b,
  input  logic                                           tile_ack,
  output logic [POLY_A_TILE_WIDTH-1:0][DATA_WIDTH-1:0]   a_tile,
  output logic [POLY_B_TILE_WIDTH-1:0][DATA_WIDTH-1:0]   b_tile,
  output logic [AIW-1:0]                                 a_idx,
  output logic [BIW-1:0]                                 b_idx,
  output logic [OW-1:0]                                  coeff_offset,
  output logic                                           tile_valid,
  output logic                                           last_tile,
  output logic                                           busy,
  output logic                                           done
);

  localparam int AAW = (POLY_A_WIDTH > 1) ? $clog2(POLY_A_WIDTH) : 1;
  localparam int BAW = (POLY_B_WIDTH > 1) ? $clog2(POLY_B_WIDTH) : 1;

  if (POLY_A_WIDTH % POLY_A_TILE_WIDTH != 0) begin : g_a_tile_chk
    $error("POLY_A_TILE_WIDTH must divide POLY_A_WIDTH");
  end
  if (POLY_B_WIDTH % POLY_B_TILE_WIDTH != 0) begin : g_b_tile_chk
    $error("POLY_B_TILE_WIDTH must divide POLY_B_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t                                  state_q, state_d;
  logic [POLY_A_WIDTH-1:0][DATA_WIDTH-1:0] a_reg_q, a_reg_d;
  logic [POLY_B_WIDTH-1:0][DATA_WIDTH-1:0] b_reg_q, b_reg_d;
  logic [AIW-1:0]                          a_idx_q, a_idx_d;
  logic [BIW-1:0]                          b_idx_q, b_idx_d;
  logic                                    a_wrap, b_wrap;
  logic [AAW-1:0]                          a_base;
  logic [BAW-1:0]                          b_base;

  assign a_wrap = (a_idx_q == AIW'(NA - 1));
  assign b_wrap = (b_idx_q == BIW'(NB - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_reg_q <= '0;
      b_reg_q <= '0;
      a_idx_q <= '0;
      b_idx_q <= '0;
    end else begin
      state_q <= state_d;
      a_reg_q <= a_reg_d;
      b_reg_q <= b_reg_d;
      a_idx_q <= a_idx_d;
      b_idx_q <= b_idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_reg_d = a_reg_q;
    b_reg_d = b_reg_q;
    a_idx_d = a_idx_q;
    b_idx_d = b_idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          a_reg_d = poly_a;
          b_reg_d = poly_b;
          a_idx_d = '0;
          b_idx_d = '0;
        end
      end
      ISSUE: begin
        // Indices only move on acceptance, so unacked tiles hold stable.
        if (tile_ack) begin
          if (a_wrap) begin
            a_idx_d = '0;
            if (b_wrap) begin
              b_idx_d = '0;
              state_d = DONE;
            end else begin
              b_idx_d = b_idx_q + 1'b1;
            end
          end else begin
            a_idx_d = a_idx_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign tile_valid = (state_q == ISSUE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign last_tile  = tile_valid && a_wrap && b_wrap;

  assign a_idx        = a_idx_q;
  assign b_idx        = b_idx_q;
  assign coeff_offset = OW'(a_idx_q) * OW'(POLY_A_TILE_WIDTH)
                      + OW'(b_idx_q) * OW'(POLY_B_TILE_WIDTH);

  // Slices are gated so the data outputs read zero whenever no tile is offered.
  assign a_base = AAW'(a_idx_q) * AAW'(POLY_A_TILE_WIDTH);
  assign b_base = BAW'(b_idx_q) * BAW'(POLY_B_TILE_WIDTH);
  assign a_tile = tile_valid ? a_reg_q[a_base +: POLY_A_TILE_WIDTH] : '0;
  assign b_tile = tile_valid ? b_reg_q[b_base +: POLY_B_TILE_WIDTH] : '0;

endmodule

// File: tb/tb_polynomial_tile_scheduler.sv
// Directed scoreboard bench for polynomial_tile_scheduler.
module tb_polynomial_tile_scheduler;

  localparam int DW = 16;
  localparam int PA = 27;
  localparam int PB = 27;
  localparam int TA = 3;
  localparam int TB = 9;
  localparam int NA = 9;
  localparam int NB = 3;
  localparam int NT = NA * NB;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic                    tile_ack;
  logic [PA-1:0][DW-1:0]   poly_a;
  logic [PB-1:0][DW-1:0]   poly_b;
  logic [TA-1:0][DW-1:0]   a_tile;
  logic [TB-1:0][DW-1:0]   b_tile;
  logic [3:0]              a_idx;
  logic [1:0]              b_idx;
  logic [5:0]              coeff_offset;
  logic                    tile_valid;
  logic                    last_tile;
  logic                    busy;
  logic                    done;

  typedef struct {
    logic [TA-1:0][DW-1:0] a;
    logic [TB-1:0][DW-1:0] b;
    int unsigned           ai;
    int unsigned           bi;
    int unsigned           off;
    logic                  last;
  } tile_t;

  tile_t       q[$];
  int unsigned errors;
  int unsigned checks;
  int unsigned valid_cnt;
  int unsigned exp_valid;
  logic        done_seen;

  polynomial_tile_scheduler #(
    .DATA_WIDTH       (DW),
    .POLY_A_WIDTH     (PA),
    .POLY_B_WIDTH     (PB),
    .POLY_A_TILE_WIDTH(TA),
    .POLY_B_TILE_WIDTH(TB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .poly_a      (poly_a),
    .poly_b      (poly_b),
    .tile_ack    (tile_ack),
    .a_tile      (a_tile),
    .b_tile      (b_tile),
    .a_idx       (a_idx),
    .b_idx       (b_idx),
    .coeff_offset(coeff_offset),
    .tile_valid  (tile_valid),
    .last_tile   (last_tile),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 256'(tile_valid), 256'(0));
    chk({tag, "_last"},  256'(last_tile),  256'(0));
    chk({tag, "_busy"},  256'(busy),       256'(0));
    chk({tag, "_done"},  256'(done),       256'(0));
    chk({tag, "_aidx"},  256'(a_idx),      256'(0));
    chk({tag, "_bidx"},  256'(b_idx),      256'(0));
    chk({tag, "_off"},   256'(coeff_offset), 256'(0));
    chk({tag, "_atile"}, 256'(a_tile),     256'(0));
    chk({tag, "_btile"}, 256'(b_tile),     256'(0));
  endtask

  // Expected tile stream derived from the operands currently on the inputs.
  task automatic push_run();
    for (int t = 0; t < NT; t++) begin
      tile_t e;
      e.ai   = t % NA;
      e.bi   = t / NA;
      e.off  = e.ai * TA + e.bi * TB;
      e.last = (t == NT - 1);
      for (int i = 0; i < TA; i++) e.a[i] = poly_a[e.ai * TA + i];
      for (int j = 0; j < TB; j++) e.b[j] = poly_b[e.bi * TB + j];
      q.push_back(e);
    end
  endtask

  task automatic monitor();
    tile_t e;
    int unsigned n;
    if (q.size() == 0) begin
      chk("unexpected_valid", 256'(tile_valid), 256'(0));
    end else if (tile_valid) begin
      e = q[0];
      n = NT - q.size();
      chk($sformatf("a_tile_t%0d", n), 256'(a_tile), 256'(e.a));
      chk($sformatf("b_tile_t%0d", n), 256'(b_tile), 256'(e.b));
      chk($sformatf("a_idx_t%0d", n),  256'(a_idx),  256'(e.ai));
      chk($sformatf("b_idx_t%0d", n),  256'(b_idx),  256'(e.bi));
      chk($sformatf("offset_t%0d", n), 256'(coeff_offset), 256'(e.off));
      chk($sformatf("last_t%0d", n),   256'(last_tile), 256'(e.last));
      chk($sformatf("busy_t%0d", n),   256'(busy), 256'(1));
      if (tile_ack) void'(q.pop_front());
    end
    if (tile_valid) valid_cnt++;
    if (done) begin
      done_seen = 1'b1;
      chk("valid_cycles", 256'(valid_cnt), 256'(exp_valid));
      chk("queue_empty_at_done", 256'(q.size()), 256'(0));
    end
  endtask

  // Sample at the falling edge, then step past the next rising edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int unsigned nvalid);
    push_run();
    valid_cnt = 0;
    exp_valid = nvalid;
    done_seen = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int unsigned max_cycles, input logic toggle_ack);
    for (int unsigned i = 0; i < max_cycles && !done_seen; i++) begin
      tick();
      if (toggle_ack) tile_ack = ~tile_ack;
    end
    chk("done_seen", 256'(done_seen), 256'(1));
    chk("done_one_cycle", 256'(done), 256'(0));
    chk("idle_after_done", 256'(busy), 256'(0));
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    valid_cnt = 0;
    exp_valid = 0;
    done_seen = 1'b0;
    rst       = 1'b0;
    start     = 1'b0;
    tile_ack  = 1'b1;
    poly_a    = '0;
    poly_b    = '0;

    #3;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_zero("idle");
    end

    // Full run with ack held high.
    for (int k = 0; k < PA; k++) poly_a[k] = 16'(k + 1);
    for (int k = 0; k < PB; k++) poly_b[k] = 16'(100 + k);
    start_run(27);
    run_until_done(40, 1'b0);

    // Backpressure: ack low in the first valid cycle, then alternating.
    start_run(54);
    tile_ack = 1'b0;
    run_until_done(120, 1'b1);
    tile_ack = 1'b1;

    // Start pulse and operand overwrite during tile 5 must not disturb the run.
    for (int k = 0; k < PA; k++) poly_a[k] = 16'(7 * k + 3);
    for (int k = 0; k < PB; k++) poly_b[k] = 16'(900 - k);
    start_run(27);
    for (int i = 0; i < 5; i++) tick();
    start  = 1'b1;
    poly_a = '0;
    poly_b = '0;
    tick();
    start = 1'b0;
    run_until_done(40, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_second_run_valid", 256'(tile_valid), 256'(0));
      chk("no_second_run_busy",  256'(busy), 256'(0));
    end

    // Asynchronous reset while tile 13 is on the outputs.
    for (int k = 0; k < PA; k++) poly_a[k] = 16'(3 * k + 7);
    for (int k = 0; k < PB; k++) poly_b[k] = 16'(500 - k);
    start_run(27);
    for (int i = 0; i < 13; i++) tick();
    chk("pre_reset_aidx", 256'(a_idx), 256'(4));
    chk("pre_reset_bidx", 256'(b_idx), 256'(1));
    #3;
    rst = 1'b0;
    #1;
    check_zero("async_rst");
    q.delete();
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("no_done_in_reset", 256'(done), 256'(0));
    end
    rst = 1'b1;
    tick();
    check_zero("post_rst_idle");

    for (int k = 0; k < PA; k++) poly_a[k] = 16'(1000 + k);
    for (int k = 0; k < PB; k++) poly_b[k] = 16'(2000 + 3 * k);
    start_run(27);
    run_until_done(40, 1'b0);

    // Back-to-back: start on the first IDLE edge after done.
    for (int k = 0; k < PA; k++) poly_a[k] = 16'(k * k);
    for (int k = 0; k < PB; k++) poly_b[k] = 16'(40000 + k);
    start_run(27);
    chk("b2b_first_valid", 256'(tile_valid), 256'(1));
    run_until_done(40, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/polynomial_tile_scheduler.md
# polynomial_tile_scheduler

Producer-side sequencer for the tiled polynomial multiplier. It captures two full operand polynomials A and B on a start pulse and walks every (A tile, B tile) pair in a fixed order. For each pair it presents the coefficient slices, tile indices and output coefficient offset over a valid/ack handshake. It drives the multiplier/adder-tree datapath whose results `polynomial_output_loader` accumulates, and is the origin of the per-tile sequence that the loader counts.

## Interface
- `DATA_WIDTH`, 16, coefficient width in bits
- `POLY_A_WIDTH`, 27, coefficients in A
- `POLY_B_WIDTH`, 27, coefficients in B
- `POLY_A_TILE_WIDTH`, 3, A coefficients per tile; must divide `POLY_A_WIDTH`
- `POLY_B_TILE_WIDTH`, 9, B coefficients per tile; must divide `POLY_B_WIDTH`
- Derived: NA = `POLY_A_WIDTH`/`POLY_A_TILE_WIDTH` (9); NB = `POLY_B_WIDTH`/`POLY_B_TILE_WIDTH` (3); OW = $clog2(`POLY_A_WIDTH`+`POLY_B_WIDTH`-1) (6)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a run; sampled only in IDLE
- `poly_a`  in  [`POLY_A_WIDTH`][`DATA_WIDTH`]  A coefficients; index 0 is x^0
- `poly_b`  in  [`POLY_B_WIDTH`][`DATA_WIDTH`]  B coefficients; index 0 is x^0
- `tile_ack`  in  1  consumer accepts the current tile
- `a_tile`  out  [`POLY_A_TILE_WIDTH`][`DATA_WIDTH`]  A slice for the current tile
- `b_tile`  out  [`POLY_B_TILE_WIDTH`][`DATA_WIDTH`]  B slice for the current tile
- `a_idx`  out  $clog2(NA)  current A tile index
- `b_idx`  out  $clog2(NB)  current B tile index
- `coeff_offset`  out  OW  `a_idx`*`POLY_A_TILE_WIDTH` + `b_idx`*`POLY_B_TILE_WIDTH`
- `tile_valid`  out  1  tile outputs are valid
- `last_tile`  out  1  the current tile is the final pair
- `busy`  out  1  a run is in progress
- `done`  out  1  one-cycle pulse at the end of a run

## Operation
- FSM states: IDLE, ISSUE, DONE.
- IDLE: if `start`=1, capture `poly_a`/`poly_b` into internal registers, set `a_idx`=`b_idx`=0, and go to ISSUE. Input changes after capture have no effect on the run.
- ISSUE: `tile_valid`=1.
  - `a_tile[i]` = A_reg[`a_idx`*`POLY_A_TILE_WIDTH`+i].
  - `b_tile[j]` = B_reg[`b_idx`*`POLY_B_TILE_WIDTH`+j].
- Ordering: A index is the inner loop and B index the outer loop. The sequence is (a,b) = (0,0),(1,0)…(NA-1,0),(0,1)…(NA-1,NB-1), for NA*NB tiles total (27).
- Handshake: a tile is consumed on a rising edge with `tile_valid`=1 and `tile_ack`=1.
  - Without ack, all tile outputs hold stable.
  - `tile_ack` while `tile_valid`=0 is ignored.
- `last_tile` = (`a_idx`=NA-1 && `b_idx`=NB-1) && `tile_valid`.
- On acceptance of the last tile, go to DONE. DONE lasts one cycle with `done`=1, `tile_valid`=0, then returns to IDLE.
- `busy` = 1 in ISSUE and DONE.
- `start` in ISSUE or DONE is ignored, with no queuing.
- `coeff_offset` is unsigned, with no overflow: max = `POLY_A_WIDTH`+`POLY_B_WIDTH`-`POLY_A_TILE_WIDTH`-`POLY_B_TILE_WIDTH` (42).
- Elaboration `$error` if either tile width does not divide its polynomial width.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE.
  - `tile_valid`, `last_tile`, `busy`, `done` = 0.
  - `a_idx`, `b_idx`, `coeff_offset` = 0.
  - `a_tile`, `b_tile` = 0; captured registers = 0.
- Reset mid-run aborts immediately. No `done` pulse is produced, and the first cycle after release is IDLE.
- All outputs are registered or decoded from registered state; there is no combinational path from `tile_ack` to any output.
- Start latency: `start` sampled at edge N gives `tile_valid`=1 with tile (0,0) during the cycle after edge N.
- Throughput: one tile per cycle with `tile_ack` held high. A full run is 27 valid cycles, then 1 DONE cycle.
- Last tile accepted at edge M gives `done`=1 in the cycle after M and `busy`=0 after edge M+1. A new `start` is accepted at edge M+2 at the earliest.

## Test plan
- Reset: drive `rst`=0 mid-clock; all outputs read 0 asynchronously. After release, hold `start`=0 for 10 cycles; outputs stay 0.
- Full run, `tile_ack`=1, `poly_a[k]`=k+1, `poly_b[k]`=100+k:
  - Tile 0 gives `a_tile`={1,2,3}, `b_tile`={100..108}, offset 0.
  - Tile 9 gives a=0, b=1, offset 9.
  - Tile 26 gives a=8, b=2, offset 42, `last_tile`=1.
  - Exactly 27 consecutive valid cycles, then `done` for 1 cycle.
- Backpressure: toggle `tile_ack` 1/0 each cycle. Each tile is held ≥2 cycles with identical outputs, all 27 tiles appear in order with none skipped or duplicated, and `done` appears after 54 cycles.
- Start while busy, plus input mutation: pulse `start` during tile 5 and overwrite `poly_a`/`poly_b` with 0. The sequence and data are unchanged, and no second run begins.
- Reset mid-run at tile 13: the outputs clear and no `done` pulse occurs. A following `start` restarts at tile (0,0) with the newly captured data.
- Back-to-back runs: assert `start` on the first IDLE edge after `done`. The second run's tile 0 appears 2 cycles after `done`.
